// File: rtl/barycentric_normalizer.sv
// Normalizes two edge magnitudes by triangle area into fixed-point barycentric weights.
// One restoring divider is shared for w0 then w1; w2 is the clamped remainder of unity.
module barycentric_normalizer #(
    parameter int FRAC_BITS  = 16,
    parameter int AREA_WIDTH = 34
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [AREA_WIDTH-1:0] area_in,
    input  logic                  negative_in,
    input  logic [AREA_WIDTH-1:0] edge0_in,
    input  logic [AREA_WIDTH-1:0] edge1_in,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [FRAC_BITS:0]    w0_out,
    output logic [FRAC_BITS:0]    w1_out,
    output logic [FRAC_BITS:0]    w2_out,
    output logic                  negative_out,
    output logic                  degenerate_out
);

    localparam int QW = FRAC_BITS + 1;
    localparam int CW = $clog2(FRAC_BITS + 2);
    localparam logic [QW-1:0] ONE = QW'(1) << FRAC_BITS;

    typedef enum logic [1:0] {IDLE, DIV0, DIV1, DONE} state_t;

    state_t                state;
    logic [AREA_WIDTH-1:0] area_q;
    logic [AREA_WIDTH-1:0] e1_q;
    logic                  neg_q;
    logic [AREA_WIDTH:0]   rem;
    logic [QW-1:0]         quo;
    logic [QW-1:0]         q0;
    logic [QW-1:0]         q1;
    logic [CW-1:0]         cnt;

    logic [AREA_WIDTH-1:0] e0_clamp;
    logic [AREA_WIDTH-1:0] e1_clamp;
    logic [AREA_WIDTH:0]   trial;
    logic                  fits;
    logic [AREA_WIDTH:0]   rem_next;
    logic [QW-1:0]         quo_next;
    logic [QW:0]           w2_diff;

    // First step compares the edge itself: edge <= area makes quotient bit FRAC_BITS valid.
    always_comb begin
        e0_clamp = (edge0_in > area_in) ? area_in : edge0_in;
        e1_clamp = (edge1_in > area_in) ? area_in : edge1_in;
        trial    = (cnt == '0) ? rem : {rem[AREA_WIDTH-1:0], 1'b0};
        fits     = trial >= {1'b0, area_q};
        rem_next = fits ? (trial - {1'b0, area_q}) : trial;
        quo_next = {quo[QW-2:0], fits};
        w2_diff  = {1'b0, ONE} - {1'b0, q0} - {1'b0, q1};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            ready_out      <= 1'b1;
            valid_out      <= 1'b0;
            w0_out         <= '0;
            w1_out         <= '0;
            w2_out         <= '0;
            negative_out   <= 1'b0;
            degenerate_out <= 1'b0;
            area_q         <= '0;
            e1_q           <= '0;
            neg_q          <= 1'b0;
            rem            <= '0;
            quo            <= '0;
            q0             <= '0;
            q1             <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in && ready_out) begin
                        area_q    <= area_in;
                        e1_q      <= e1_clamp;
                        neg_q     <= negative_in;
                        rem       <= {1'b0, e0_clamp};
                        quo       <= '0;
                        cnt       <= '0;
                        ready_out <= 1'b0;
                        state     <= DIV0;
                    end
                end
                DIV0: begin
                    if (area_q == '0) begin
                        w0_out         <= '0;
                        w1_out         <= '0;
                        w2_out         <= '0;
                        negative_out   <= neg_q;
                        degenerate_out <= 1'b1;
                        valid_out      <= 1'b1;
                        state          <= DONE;
                    end else if (cnt == CW'(FRAC_BITS)) begin
                        q0    <= quo_next;
                        rem   <= {1'b0, e1_q};
                        quo   <= '0;
                        cnt   <= '0;
                        state <= DIV1;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV1: begin
                    // Extra finalize cycle forms w2 from registered quotients.
                    if (cnt == CW'(FRAC_BITS + 1)) begin
                        w0_out         <= q0;
                        w1_out         <= q1;
                        w2_out         <= w2_diff[QW] ? '0 : w2_diff[QW-1:0];
                        negative_out   <= neg_q;
                        degenerate_out <= 1'b0;
                        valid_out      <= 1'b1;
                        state          <= DONE;
                    end else begin
                        rem <= rem_next;
                        quo <= quo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(FRAC_BITS))
                            q1 <= quo_next;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/barycentric_normalizer.md
Name: barycentric_normalizer

Overview:
- Downstream consumer of the triangle area stage in the rasterizer.
- Takes the unsigned triangle area and two per-pixel unsigned edge-function magnitudes, and produces normalized fixed-point barycentric weights w0, w1, w2 for attribute interpolation.
- Uses one shared sequential restoring divider, one quotient bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- FRAC_BITS, 16, fractional bits of each weight; weight 1.0 = 2^FRAC_BITS.
- AREA_WIDTH, 34, width of the area and edge magnitudes; matches the area stage output.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- valid_in  input  1  input transaction valid
- ready_out  output  1  block can accept an input
- area_in  input  AREA_WIDTH  unsigned triangle area (divisor)
- negative_in  input  1  winding flag from the area stage; passed through
- edge0_in  input  AREA_WIDTH  unsigned edge magnitude for vertex 0
- edge1_in  input  AREA_WIDTH  unsigned edge magnitude for vertex 1
- valid_out  output  1  result valid
- ready_in  input  1  downstream accepts the result
- w0_out  output  FRAC_BITS+1  weight 0, unsigned, range 0..2^FRAC_BITS
- w1_out  output  FRAC_BITS+1  weight 1
- w2_out  output  FRAC_BITS+1  weight 2
- negative_out  output  1  registered copy of negative_in
- degenerate_out  output  1  area_in was zero

Behaviour:
- Reset (asynchronous, any state): state=IDLE; ready_out=1; valid_out=0; all weights=0; negative_out=0; degenerate_out=0; any in-flight transaction is discarded.
- States: IDLE, DIV0, DIV1, DONE.
- IDLE:
  - ready_out=1.
  - On valid_in&&ready_out at clock edge k, capture area, edges and negative; ready_out drops after edge k.
  - If area_in==0: go to DONE with degenerate_out=1, weights 0, valid_out=1 after edge k+1.
  - Otherwise go to DIV0.
- Clamping: each edge is clamped to area before division (edge>area gives exactly 2^FRAC_BITS).
- DIV0: computes w0=floor(edge0*2^FRAC_BITS/area) by restoring division.
  - FRAC_BITS+1 cycles, MSB first.
  - Remainder register AREA_WIDTH+1 bits wide (holds 2*area without overflow).
- DIV1: same computation for w1, FRAC_BITS+1 cycles.
- Entry to DONE from DIV1:
  - w2 = 2^FRAC_BITS - w0 - w1, computed at FRAC_BITS+2 signed width; if negative, clamp to 0.
  - valid_out=1 and degenerate_out=0.
  - Latency: valid_out is high after edge k+2*(FRAC_BITS+1)+1, i.e. 35 cycles for the default.
- DONE:
  - All outputs held stable while valid_out&&!ready_in.
  - On valid_out&&ready_in: go to IDLE; valid_out=0 and ready_out=1 after that edge.
  - No same-cycle input acceptance in DONE; valid_in is ignored while ready_out=0.
- negative_out is not used in the arithmetic; it updates together with the weights.
- Weights are not modified after the handshake until the next result is loaded.

Test Plan:
- Balanced split: area=100, e0=25, e1=50 -> w0=16384, w1=32768, w2=16384, degenerate_out=0; valid_out 35 cycles after the accept edge.
- Rounding: area=3, e0=1, e1=1 -> w0=21845, w1=21845, w2=21846.
- Degenerate: area=0, any edges -> valid_out after 1 cycle, degenerate_out=1, w0=w1=w2=0.
- Clamp and negative w2: area=100, e0=150, e1=10 -> w0=65536, w1=6553, w2=0. Separately negative_in=1 -> negative_out=1.
- Backpressure: hold ready_in=0 for 10 cycles after valid_out -> outputs stable and ready_out=0 throughout; a valid_in pulse during that window is not captured; ready_out=1 the cycle after ready_in=1.
- Reset mid-DIV0: assert rst_in at cycle 5 of DIV0 -> valid_out=0 and ready_out=1 immediately; a following transaction (area=100, e0=25, e1=50) produces the correct weights.
